snn_core_scheduler: RTL and testbench
=====================================

Name: snn_core_scheduler

Overview:
- Wishbone-programmed sequencer for the dual SNN cores. It runs a configured number of time steps.
- Per step: issues a one-cycle start pulse to each selected core, waits for each core's done, then pulses enable_calc_o so the output spike memory latches that core's 256-bit spike vector.
- Supports parallel mode (both cores per step) and chained mode (core0 then core1).
- Drives core_en_o to select the output spike memory readback bank.

Parameters:
- SCHED_BASE, 32'h80060000, Wishbone base address of the 3-word register block.
- STEP_W, 16, width of the step counter and of NUM_STEPS.

Ports:
- wb_clk_i  in  1  clock; all logic on its rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_sel_i  in  4  byte lanes; writes honour lanes, reads return full word.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- core_start_o  out  2  one-cycle start pulse per core.
- core_done_i  in  2  per-core done pulse (may be level; only rising is required).
- enable_calc_o  out  2  one-cycle latch pulse to the output spike memory, per core.
- core_en_o  out  2  readback bank select, equals CTRL.mask.
- busy_o  out  1  high while a run is in progress.
- irq_o  out  1  equals STATUS.done.

Behaviour:
- Reset (sync): all outputs 0, all registers 0, FSM in IDLE.
- Address decode: offsets 0x0/0x4/0x8 from SCHED_BASE, word-aligned.
  - Out-of-range addresses get no ack; wbs_dat_o holds its value.
- Bus handshake:
  - Ack is registered: asserted the cycle after cyc&stb on a hit, low the following cycle.
  - A held request yields an ack pulse every other cycle.
  - Read data is valid with the ack.
- Register 0x0 CTRL (R/W):
  - bit0 start: write-1, self-clearing, reads 0.
  - bits2:1 mask (bit1 = core0, bit2 = core1).
  - bit3 mode (0 = parallel, 1 = chained).
  - bit4 abort: write-1, reads 0.
- Register 0x4 NUM_STEPS (R/W): bits STEP_W-1:0.
- Register 0x8 STATUS (RO):
  - bit0 busy, bit1 done, bit2 aborted, bits 31:16 steps completed.
  - Writes are acked and ignored.
- While busy: writes to mask, mode or NUM_STEPS are acked and ignored; only abort acts.
- Start conditions:
  - Start while busy: ignored.
  - Start in IDLE with NUM_STEPS = 0 or mask = 0: no run; done = 1 next cycle; step count = 0.
  - Accepted start: clears done, aborted and step count; per-core sticky done flags cleared; busy_o = 1.
- FSM states: IDLE, ISSUE, WAIT, LATCH, NEXT.
- Parallel mode:
  - ISSUE (1 cycle): core_start_o = mask.
  - WAIT: until the sticky flags cover all masked cores.
  - LATCH (1 cycle): enable_calc_o = mask.
  - NEXT: step++. If step == NUM_STEPS: IDLE, done = 1, busy = 0. Otherwise clear the flags and go to ISSUE.
- Chained mode (both mask bits are required; a single bit behaves as parallel):
  - Per step: ISSUE core0 → WAIT done0 → LATCH enable_calc_o = 2'b01 → ISSUE core1 → WAIT done1 → LATCH 2'b10 → NEXT.
- Sticky done flags:
  - Set on core_done_i high in any non-IDLE state, including the ISSUE cycle itself.
  - Cleared on each ISSUE entry, before that cycle's capture.
  - core_done_i from an unmasked core is ignored.
- Minimum step latency, parallel, done arriving the cycle after start: ISSUE, WAIT, LATCH, NEXT = 4 cycles.
- Abort while busy:
  - Next cycle: FSM to IDLE, busy = 0, aborted = 1, done unchanged (0).
  - No further start or enable_calc pulses; step count holds.
- Simultaneous abort and start in one write: abort wins; nothing starts.
- Step counter: wraps at 2^STEP_W, which is unreachable since it stops at NUM_STEPS.
- STATUS bits 31:16 are zero-extended when STEP_W < 16.
- Reset mid-run returns everything to the reset state the next edge.

Test Plan:
- Reset then read STATUS and CTRL -> both 0x0; all outputs 0.
- Write NUM_STEPS = 3, CTRL = 0x7 (mask = 11, parallel, start); done pulses 2 cycles after each start.
  - Required: 3 core_start_o = 2'b11 pulses and 3 enable_calc_o = 2'b11 pulses.
  - Final STATUS = 0x00030002; irq_o = 1.
- Chained mode, NUM_STEPS = 2, CTRL = 0xF -> pulse order per step: start 01, calc 01, start 10, calc 10. Final STATUS = 0x00020002.
- Mid-run, core1 done never comes; write CTRL = 0x10.
  - Required: busy = 0 the next cycle, STATUS bit2 = 1, no further enable_calc pulses.
- Writes during a run:
  - NUM_STEPS = 9 while busy -> ignored, readback keeps the old value.
  - Start while busy -> no restart.
  - NUM_STEPS = 0 then start -> done = 1 with no core_start pulses.
- Assert wb_rst_i during WAIT -> all outputs 0 after the edge.
- Out-of-range address read -> no ack.
- Done asserted during the ISSUE cycle -> counted; step completes in 4 cycles.

Source files
------------

// File: rtl/snn_core_scheduler.sv
// snn_core_scheduler: Wishbone-programmed step sequencer for the dual SNN cores.
// Ports: wb_clk_i/wb_rst_i clock and sync reset; wbs_* Wishbone slave with
// CTRL/NUM_STEPS/STATUS; core_start_o/core_done_i core handshake;
// enable_calc_o spike latch pulses; core_en_o bank select; busy_o; irq_o.
module snn_core_scheduler #(
   parameter logic [31:0] SCHED_BASE = 32'h8006_0000,
   parameter int unsigned STEP_W     = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [1:0]  core_start_o,
   input  logic [1:0]  core_done_i,
   output logic [1:0]  enable_calc_o,
   output logic [1:0]  core_en_o,
   output logic        busy_o,
   output logic        irq_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_LATCH,
      S_NEXT
   } state_e;

   state_e state_q, state_d;

   logic              ack_q;
   logic [31:0]       dat_q;
   logic [1:0]        mask_q, mask_d;
   logic              mode_q, mode_d;
   logic [STEP_W-1:0] nsteps_q, nsteps_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;
   logic [1:0]        sticky_q, sticky_d;
   logic              phase_q, phase_d;

   logic [31:0]       offs;
   logic              addr_hit;
   logic [1:0]        off;
   logic              req;
   logic              wr_ctrl;
   logic              wr_nst;
   logic              idle;
   logic              abort_req;
   logic              start_req;
   logic              run_ok;
   logic              chained;
   logic [1:0]        cur_mask;
   logic [1:0]        flags_now;
   logic              wait_ok;
   logic [STEP_W-1:0] step_inc;
   logic              last;
   logic [31:0]       rdata;
   logic [31:0]       nst_wr;
   logic              unused_bits;

   // Address decode: three word-aligned registers above SCHED_BASE.
   assign offs     = wbs_adr_i - SCHED_BASE;
   assign off      = offs[3:2];
   assign addr_hit = (offs[31:4] == '0) && (offs[3:2] != 2'b11)
                     && (offs[1:0] == 2'b00);
   // Gating on ack_q gives one ack every other cycle for a held request.
   assign req      = wbs_cyc_i && wbs_stb_i && addr_hit && !ack_q;
   assign wr_ctrl  = req && wbs_we_i && (off == 2'd0) && wbs_sel_i[0];
   assign wr_nst   = req && wbs_we_i && (off == 2'd1);

   assign idle      = (state_q == S_IDLE);
   assign abort_req = wr_ctrl && wbs_dat_i[4];
   assign start_req = wr_ctrl && wbs_dat_i[0] && !wbs_dat_i[4];
   // The start write may carry the mask itself, so judge it on wbs_dat_i.
   assign run_ok    = start_req && idle && (wbs_dat_i[2:1] != 2'b00)
                      && (nsteps_q != '0);

   // Chaining needs both cores; a single selected core runs as parallel.
   assign chained  = mode_q && (mask_q == 2'b11);
   assign cur_mask = chained ? (phase_q ? 2'b10 : 2'b01) : mask_q;

   // ISSUE discards old flags but still captures a done seen that cycle;
   // WAIT looks at the live done too so a one-cycle response costs no slot.
   assign flags_now = ((state_q == S_ISSUE) ? 2'b00 : sticky_q)
                      | (core_done_i & cur_mask);
   assign wait_ok   = ((flags_now & cur_mask) == cur_mask);

   assign step_inc = step_q + 1'b1;
   assign last     = (step_inc == nsteps_q);

   always_comb begin
      nst_wr = 32'(nsteps_q);
      for (int i = 0; i < 4; i++) begin
         if (wbs_sel_i[i]) nst_wr[8*i +: 8] = wbs_dat_i[8*i +: 8];
      end
   end
   assign unused_bits = ^nst_wr;

   always_comb begin
      rdata = '0;
      unique case (off)
         2'd0:    rdata = {27'd0, 1'b0, mode_q, mask_q, 1'b0};
         2'd1:    rdata = 32'(nsteps_q);
         2'd2:    rdata = {16'(step_q), 13'd0, aborted_q, done_q, !idle};
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= req;
         if (req && !wbs_we_i) dat_q <= rdata;
      end
   end

   // FSM: state register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // FSM: next state.
   always_comb begin
      state_d = state_q;
      if (!idle && abort_req) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:  if (run_ok) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (wait_ok) state_d = S_LATCH;
            S_LATCH: state_d = (chained && !phase_q) ? S_ISSUE : S_NEXT;
            S_NEXT:  state_d = last ? S_IDLE : S_ISSUE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM: outputs.
   always_comb begin
      core_start_o  = 2'b00;
      enable_calc_o = 2'b00;
      if (state_q == S_ISSUE) core_start_o  = cur_mask;
      if (state_q == S_LATCH) enable_calc_o = cur_mask;
   end

   // Datapath next state: config, status and per-step bookkeeping.
   always_comb begin
      mask_d    = mask_q;
      mode_d    = mode_q;
      nsteps_d  = nsteps_q;
      step_d    = step_q;
      done_d    = done_q;
      aborted_d = aborted_q;
      phase_d   = phase_q;
      sticky_d  = idle ? sticky_q : flags_now;
      if (wr_ctrl && idle) begin
         mask_d = wbs_dat_i[2:1];
         mode_d = wbs_dat_i[3];
      end
      if (wr_nst && idle) nsteps_d = nst_wr[STEP_W-1:0];
      if (idle && start_req) begin
         done_d    = !run_ok;
         aborted_d = 1'b0;
         step_d    = '0;
         sticky_d  = 2'b00;
         phase_d   = 1'b0;
      end else if (!idle && abort_req) begin
         aborted_d = 1'b1;
      end else if (state_q == S_LATCH) begin
         if (chained && !phase_q) phase_d = 1'b1;
      end else if (state_q == S_NEXT) begin
         step_d  = step_inc;
         phase_d = 1'b0;
         if (last) done_d = 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         mask_q    <= '0;
         mode_q    <= 1'b0;
         nsteps_q  <= '0;
         step_q    <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         sticky_q  <= '0;
         phase_q   <= 1'b0;
      end else begin
         mask_q    <= mask_d;
         mode_q    <= mode_d;
         nsteps_q  <= nsteps_d;
         step_q    <= step_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         sticky_q  <= sticky_d;
         phase_q   <= phase_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign core_en_o = mask_q;
   assign busy_o    = !idle;
   assign irq_o     = done_q;

endmodule

// File: tb/tb_snn_core_scheduler.sv
// tb_snn_core_scheduler: directed and randomized runs of the SNN scheduler
// against a step-level model of pulse order, run length and STATUS.
module tb_snn_core_scheduler;

   localparam logic [31:0] BASE = 32'h8006_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  sel = 4'hF;
   logic [31:0] adr = '0;
   logic [31:0] wdat = '0;
   logic        ack;
   logic [31:0] rdat;
   logic [1:0]  core_start;
   logic [1:0]  core_done = 2'b00;
   logic [1:0]  enable_calc;
   logic [1:0]  core_en;
   logic        busy;
   logic        irq;

   snn_core_scheduler #(
      .SCHED_BASE(BASE),
      .STEP_W(16)
   ) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .wbs_cyc_i(cyc),
      .wbs_stb_i(stb),
      .wbs_we_i(we),
      .wbs_sel_i(sel),
      .wbs_adr_i(adr),
      .wbs_dat_i(wdat),
      .wbs_ack_o(ack),
      .wbs_dat_o(rdat),
      .core_start_o(core_start),
      .core_done_i(core_done),
      .enable_calc_o(enable_calc),
      .core_en_o(core_en),
      .busy_o(busy),
      .irq_o(irq)
   );

   always #5 clk = ~clk;

   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] evq[$];
   logic [3:0] expq[$];
   int         bcnt = 0;
   int         dly[2] = '{1, 1};
   bit         never[2] = '{0, 0};
   int         cnt[2] = '{0, 0};
   logic       post_ack;
   logic       post_busy;
   logic [31:0] rd;
   int         ecyc;
   int         acks;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Core model: done pulse dly cycles after the start cycle (0 = same cycle).
   task automatic service();
      core_done = 2'b00;
      for (int c = 0; c < 2; c++) begin
         if (cnt[c] > 0) begin
            cnt[c]--;
            if (cnt[c] == 0) core_done[c] = 1'b1;
         end
      end
      for (int c = 0; c < 2; c++) begin
         if (core_start[c] === 1'b1 && !never[c]) begin
            if (dly[c] == 0) core_done[c] = 1'b1;
            else cnt[c] = dly[c];
         end
      end
      if (|core_start === 1'b1) evq.push_back({2'b01, core_start});
      if (|enable_calc === 1'b1) evq.push_back({2'b10, enable_calc});
      if (busy === 1'b1) bcnt++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      service();
   endtask

   task automatic wb_write(input logic [31:0] off, input logic [31:0] d);
      adr = BASE + off; wdat = d; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      step();
      post_ack = ack; post_busy = busy;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      step();
   endtask

   task automatic wb_read(input logic [31:0] off, output logic [31:0] d);
      adr = BASE + off; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      step();
      post_ack = ack; d = rdat;
      cyc = 1'b0; stb = 1'b0;
      step();
   endtask

   task automatic run_to_idle(input int limit);
      for (int n = 0; n < limit && busy === 1'b1; n++) step();
      chk("run_timeout", {31'd0, busy}, 32'd0);
   endtask

   function automatic int mx(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Step-level model: expected pulse list and busy length of one run.
   function automatic int model(input int mask, input int mode, input int n);
      int cyc_n = 0;
      int d;
      expq.delete();
      for (int s = 0; s < n; s++) begin
         if (mode == 1 && mask == 3) begin
            expq.push_back(4'b0101); expq.push_back(4'b1001);
            expq.push_back(4'b0110); expq.push_back(4'b1010);
            cyc_n += 2 + mx(1, dly[0]) + 2 + mx(1, dly[1]) + 1;
         end else begin
            expq.push_back({2'b01, 2'(mask)});
            expq.push_back({2'b10, 2'(mask)});
            d = 0;
            if (mask & 1) d = mx(d, dly[0]);
            if (mask & 2) d = mx(d, dly[1]);
            cyc_n += 3 + mx(1, d);
         end
      end
      return cyc_n;
   endfunction

   task automatic cmp_events(input string tag);
      chk({tag, "_count"}, evq.size(), expq.size());
      for (int i = 0; i < evq.size() && i < expq.size(); i++)
         chk({tag, "_pulse"}, {28'd0, evq[i]}, {28'd0, expq[i]});
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_start"}, {30'd0, core_start}, 32'd0);
      chk({tag, "_calc"}, {30'd0, enable_calc}, 32'd0);
      chk({tag, "_en"}, {30'd0, core_en}, 32'd0);
      chk({tag, "_busy_irq"}, {30'd0, busy, irq}, 32'd0);
      chk({tag, "_ack"}, {31'd0, ack}, 32'd0);
      chk({tag, "_dat"}, rdat, 32'd0);
   endtask

   task automatic do_run(input string tag, input int mask, input int mode,
                         input int n);
      evq.delete(); bcnt = 0;
      ecyc = model(mask, mode, n);
      wb_write(32'h4, 32'(n));
      wb_write(32'h0, {28'd0, 1'(mode), 2'(mask), 1'b1});
      chk({tag, "_busy"}, {31'd0, post_busy}, 32'd1);
      run_to_idle(400);
      cmp_events(tag);
      chk({tag, "_cycles"}, 32'(bcnt), 32'(ecyc));
      wb_read(32'h8, rd);
      chk({tag, "_status"}, rd, {16'(n), 16'h0002});
      chk({tag, "_irq"}, {31'd0, irq}, 32'd1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) step();
      chk_outs_zero("reset");
      rst = 1'b0;
      step();
      wb_read(32'h8, rd);
      chk("reset_status", rd, 32'd0);
      chk("reset_ack", {31'd0, post_ack}, 32'd1);
      wb_read(32'h0, rd);
      chk("reset_ctrl", rd, 32'd0);

      dly = '{2, 2};
      do_run("par3", 3, 0, 3);
      wb_read(32'h0, rd);
      chk("ctrl_readback", rd, 32'h6);

      dly = '{1, 2};
      do_run("chain2", 3, 1, 2);

      dly = '{0, 0};
      do_run("issue_done", 3, 0, 1);

      for (int r = 0; r < 6; r++) begin
         dly[0] = $urandom_range(0, 3);
         dly[1] = $urandom_range(0, 3);
         do_run($sformatf("rnd%0d", r), $urandom_range(1, 3),
                $urandom_range(0, 1), $urandom_range(1, 4));
      end

      // Config writes and a second start while a run is in flight.
      dly = '{4, 4};
      evq.delete(); bcnt = 0;
      ecyc = model(3, 0, 2);
      wb_write(32'h4, 32'd2);
      wb_write(32'h0, 32'h7);
      wb_write(32'h4, 32'd9);
      chk("busy_wr_ack", {31'd0, post_ack}, 32'd1);
      wb_write(32'h0, 32'h7);
      wb_write(32'h0, 32'h9);
      wb_read(32'h4, rd);
      chk("busy_nsteps", rd, 32'd2);
      wb_read(32'h0, rd);
      chk("busy_ctrl", rd, 32'h6);
      run_to_idle(400);
      cmp_events("busy_wr");
      chk("busy_wr_cycles", 32'(bcnt), 32'(ecyc));
      wb_read(32'h8, rd);
      chk("busy_wr_status", rd, 32'h0002_0002);

      // Abort while core1 never answers.
      dly = '{1, 1};
      never[1] = 1'b1;
      evq.delete();
      wb_write(32'h4, 32'd3);
      wb_write(32'h0, 32'h7);
      repeat (4) step();
      wb_write(32'h0, 32'h10);
      chk("abort_busy", {31'd0, post_busy}, 32'd0);
      repeat (6) step();
      expq.delete();
      expq.push_back(4'b0111);
      cmp_events("abort");
      wb_read(32'h8, rd);
      chk("abort_status", rd, 32'h0000_0004);
      chk("abort_irq", {31'd0, irq}, 32'd0);
      never[1] = 1'b0;
      cnt = '{0, 0};

      // Zero steps: done without any core activity.
      evq.delete();
      wb_write(32'h4, 32'd0);
      wb_write(32'h0, 32'h7);
      chk("zero_busy", {31'd0, post_busy}, 32'd0);
      repeat (3) step();
      chk("zero_pulses", evq.size(), 32'd0);
      wb_read(32'h8, rd);
      chk("zero_status", rd, 32'h0000_0002);

      // Empty mask: same outcome.
      wb_write(32'h4, 32'd2);
      wb_write(32'h0, 32'h1);
      repeat (3) step();
      chk("mask0_pulses", evq.size(), 32'd0);
      chk("mask0_en", {30'd0, core_en}, 32'd0);
      wb_read(32'h8, rd);
      chk("mask0_status", rd, 32'h0000_0002);

      // Abort and start in one write: nothing starts.
      wb_write(32'h0, 32'h17);
      chk("absta_busy", {31'd0, post_busy}, 32'd0);
      repeat (4) step();
      chk("absta_pulses", evq.size(), 32'd0);
      wb_read(32'h8, rd);
      chk("absta_status", rd, 32'h0000_0002);

      // Held request acks every other cycle.
      acks = 0;
      adr = BASE + 32'h4; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      repeat (4) begin
         step();
         if (ack === 1'b1) acks++;
      end
      cyc = 1'b0; stb = 1'b0;
      step();
      chk("held_acks", 32'(acks), 32'd2);
      chk("held_data", rdat, 32'd2);

      // Out-of-range and misaligned reads: no ack, data holds.
      adr = BASE + 32'hC; cyc = 1'b1; stb = 1'b1;
      step();
      chk("oor_ack", {31'd0, ack}, 32'd0);
      chk("oor_dat", rdat, 32'd2);
      adr = BASE + 32'h2;
      step();
      chk("misal_ack", {31'd0, ack}, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      step();

      // Reset while waiting on a core.
      never[1] = 1'b1;
      wb_write(32'h4, 32'd3);
      wb_write(32'h0, 32'h7);
      repeat (3) step();
      chk("prerst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      step();
      chk_outs_zero("midrst");
      rst = 1'b0;
      never[1] = 1'b0;
      cnt = '{0, 0};
      step();
      wb_read(32'h8, rd);
      chk("midrst_status", rd, 32'd0);
      wb_read(32'h4, rd);
      chk("midrst_nsteps", rd, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
